// File: rtl/ctrl_shift_reader_8b_pkg.sv
// Shared constants and state encoding for the controller-port shift reader.
package ctrl_shift_reader_8b_pkg;
    localparam int CTRL_WIDTH_DEFAULT = 8;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    typedef enum logic [1:0] {
        LOAD      = 2'd0,
        SHIFT     = 2'd1,
        EXHAUSTED = 2'd2
    } ctrl_state_t;
endpackage

// File: rtl/ctrl_shift_reader_8b_if.sv
// Pad-register bus: load/read controls in, serial bit and progress out.
// Optional CTRL_OPEN_BUS_EN adds the floating-bus sample input.
interface ctrl_shift_reader_8b_if #(
    parameter int WIDTH = 8
);
    logic                       strobe;
    logic [WIDTH-1:0]           buttons;
    logic                       rd_en;
    logic                       serial_out;
    logic [$clog2(WIDTH+1)-1:0] bit_count;
    logic                       done;
`ifdef CTRL_OPEN_BUS_EN
    logic                       open_bus_in;

    modport master (output strobe, buttons, rd_en, open_bus_in,
                    input  serial_out, bit_count, done);
    modport slave  (input  strobe, buttons, rd_en, open_bus_in,
                    output serial_out, bit_count, done);
`else
    modport master (output strobe, buttons, rd_en,
                    input  serial_out, bit_count, done);
    modport slave  (input  strobe, buttons, rd_en,
                    output serial_out, bit_count, done);
`endif
endinterface

// File: rtl/ctrl_shift_reader_8b_shift_cell_1b.sv
// One loadable shift stage; load has priority over shift.
module shift_cell_1b (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic load_d,
    input  logic shift_en,
    input  logic shift_d,
    output logic q
);
    always_ff @(posedge clk) begin
        if (rst)           q <= 1'b0;
        else if (load)     q <= load_d;
        else if (shift_en) q <= shift_d;
    end
endmodule

// File: rtl/ctrl_shift_reader_8b.sv
// 4021-style pad register: parallel capture while strobe is high, then LSB-first serial reads.
// Build option CTRL_OPEN_BUS_EN: exhausted reads follow a registered open_bus_in.
module ctrl_shift_reader_8b
    import ctrl_shift_reader_8b_pkg::*;
#(
    parameter int   WIDTH        = CTRL_WIDTH_DEFAULT,
    parameter logic OVERREAD_VAL = 1'b1
) (
    input logic                   clk,
    input logic                   rst,
    ctrl_shift_reader_8b_if.slave bus
);
    localparam int CW = $clog2(WIDTH+1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    ctrl_state_t      state_q, state_n;
    logic [WIDTH-1:0] sh;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic             so_q, so_n;
    logic             done_q, done_n;
    logic             do_load, do_shift;

    assign do_load  = bus.strobe;
    assign do_shift = !bus.strobe && bus.rd_en && (state_q != EXHAUSTED);

    // MSB stage takes the overread fill; every other stage takes its upper neighbour.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic nxt;
        if (i == WIDTH-1) begin : g_top
            assign nxt = OVERREAD_VAL;
        end else begin : g_mid
            assign nxt = sh[i+1];
        end
        shift_cell_1b u_cell (
            .clk      (clk),
            .rst      (rst),
            .load     (do_load),
            .load_d   (bus.buttons[i]),
            .shift_en (do_shift),
            .shift_d  (nxt),
            .q        (sh[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EXHAUSTED;
            cnt_q   <= CNT_MAX;
            so_q    <= OVERREAD_VAL;
            done_q  <= 1'b1;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            so_q    <= so_n;
            done_q  <= done_n;
        end
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        so_n    = so_q;
        done_n  = done_q;
        if (do_load) begin
            state_n = LOAD;
            cnt_n   = '0;
            so_n    = bus.buttons[0];
            done_n  = 1'b0;
        end else if (do_shift) begin
            cnt_n = cnt_q + 1'b1;
            if (cnt_n == CNT_MAX) begin
                state_n = EXHAUSTED;
                so_n    = OVERREAD_VAL;
                done_n  = 1'b1;
            end else begin
                state_n = SHIFT;
                so_n    = sh[1];
            end
        end else if (state_q == LOAD) begin
            state_n = SHIFT;
        end
`ifdef CTRL_OPEN_BUS_EN
        // Floating data bus: once exhausted, reads see whatever was last on the bus.
        if (!do_load && !do_shift && state_q == EXHAUSTED)
            so_n = bus.open_bus_in;
`endif
    end

    assign bus.serial_out = so_q;
    assign bus.bit_count  = cnt_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_ctrl_shift_reader_8b.sv
// Directed self-checking bench for ctrl_shift_reader_8b (WIDTH=8, OVERREAD_VAL=1).
module tb_ctrl_shift_reader_8b;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    ctrl_shift_reader_8b_if #(.WIDTH(8)) bus ();

    ctrl_shift_reader_8b #(.WIDTH(8), .OVERREAD_VAL(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input logic so, input logic [3:0] cnt, input logic dn);
        chk({tag, ".serial_out"}, 32'(bus.serial_out), 32'(so));
        chk({tag, ".bit_count"},  32'(bus.bit_count),  32'(cnt));
        chk({tag, ".done"},       32'(bus.done),       32'(dn));
    endtask

    task automatic load(input logic [7:0] b);
        bus.buttons = b;
        bus.strobe  = 1'b1;
        cycle();
        bus.strobe  = 1'b0;
    endtask

    task automatic rd();
        bus.rd_en = 1'b1;
        cycle();
        bus.rd_en = 1'b0;
    endtask

    logic [7:0] seq_a5;

    initial begin
        rst = 1'b1;
        bus.strobe  = 1'b0;
        bus.rd_en   = 1'b0;
        bus.buttons = 8'h00;
`ifdef CTRL_OPEN_BUS_EN
        bus.open_bus_in = 1'b1;
`endif
        cycle();
        rst = 1'b0;
        outs("reset", 1'b1, 4'd8, 1'b1);

        bus.rd_en = 1'b1;
        repeat (10) cycle();
        bus.rd_en = 1'b0;
        outs("idle_reads", 1'b1, 4'd8, 1'b1);

        // 8'b1010_0101 read LSB first
        seq_a5 = 8'b1010_0101;
        load(8'hA5);
        outs("load_a5", 1'b1, 4'd0, 1'b0);
        cycle();
        chk("a5_hold_count", 32'(bus.bit_count), 32'd0);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("a5_bit%0d", k), 32'(bus.serial_out), 32'(seq_a5[k]));
            rd();
            chk($sformatf("a5_cnt%0d", k), 32'(bus.bit_count), 32'(k + 1));
        end
        outs("a5_done", 1'b1, 4'd8, 1'b1);
        rd();
        chk("a5_read9", 32'(bus.serial_out), 32'd1);
        rd();
        outs("a5_read10", 1'b1, 4'd8, 1'b1);

        bus.buttons = 8'h01;
        bus.strobe  = 1'b1;
        bus.rd_en   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            outs($sformatf("strobe_wins%0d", k), 1'b1, 4'd0, 1'b0);
        end
        bus.strobe  = 1'b0;
        bus.rd_en   = 1'b0;
        bus.buttons = 8'h02;
        cycle();
        outs("btn_change_ignored", 1'b1, 4'd0, 1'b0);
        rd();
        outs("after_first_read", 1'b0, 4'd1, 1'b0);

        load(8'hFF);
        repeat (3) rd();
        outs("ff_3reads", 1'b1, 4'd3, 1'b0);
        load(8'h00);
        outs("reload_00", 1'b0, 4'd0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("reload_bit%0d", k), 32'(bus.serial_out), 32'd0);
            rd();
        end
        outs("reload_exhausted", 1'b1, 4'd8, 1'b1);

        load(8'h00);
        rd();
        rd();
        outs("pre_reset", 1'b0, 4'd2, 1'b0);
        rst = 1'b1;
        bus.rd_en = 1'b1;
        cycle();
        rst = 1'b0;
        outs("reset_mid_shift", 1'b1, 4'd8, 1'b1);
        cycle();
        bus.rd_en = 1'b0;
        outs("after_reset_read", 1'b1, 4'd8, 1'b1);

`ifdef CTRL_OPEN_BUS_EN
        load(8'h00);
        repeat (8) rd();
        outs("ob_exhausted", 1'b1, 4'd8, 1'b1);
        bus.open_bus_in = 1'b0;
        cycle();
        chk("ob_follow0", 32'(bus.serial_out), 32'd0);
        bus.open_bus_in = 1'b1;
        cycle();
        chk("ob_follow1", 32'(bus.serial_out), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ctrl_shift_reader_8b.md
Name: ctrl_shift_reader_8b

Overview:
- Reader side of the controller-port latch path: parallel-captures a button word while `strobe` is high, then shifts it out one bit per read pulse.
- Behaves like the NES 4021-style pad register.
- Sits between the button-latch bank and the $4016/$4017 read logic of the CPU bus interface.
- Everything is registered on one clock, so the CPU side sees a deterministic serial stream.

Parameters:
- WIDTH, 8, number of button bits captured and shifted. Legal range is 2..16.
- OVERREAD_VAL, 1'b1, serial value returned once all WIDTH bits have been read.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- strobe  in  1  level load-enable. While 1, the register continuously reloads from `buttons`.
- buttons  in  WIDTH  parallel button word; bit 0 (A) is shifted out first.
- rd_en  in  1  read pulse; each cycle high with strobe=0 advances one bit.
- serial_out  out  1  current bit presented to the CPU data bus bit 0.
- bit_count  out  $clog2(WIDTH+1)  number of bits already consumed, 0..WIDTH.
- done  out  1  high when bit_count==WIDTH.

Behaviour:
- Reset (rst=1 at edge):
  - shift register <= 0
  - bit_count <= WIDTH
  - done <= 1
  - serial_out <= OVERREAD_VAL
  - rst has priority over strobe and rd_en.
- States:
  - LOAD: strobe=1.
  - SHIFT: strobe=0 and bit_count<WIDTH.
  - EXHAUSTED: strobe=0 and bit_count==WIDTH.
- LOAD behaviour: every edge with strobe=1:
  - shift <= buttons
  - bit_count <= 0
  - serial_out <= buttons[0]
  - done <= 0
  - rd_en is ignored; strobe wins on any simultaneous event.
- LOAD -> SHIFT on the first edge with strobe=0. The register holds the last word sampled while strobe was high, i.e. the value at the final strobe=1 edge.
- SHIFT behaviour: edge with rd_en=1:
  - shift <= {fill, shift[WIDTH-1:1]}
  - bit_count <= bit_count+1
  - serial_out <= shift[1] (or the fill value on the last shift)
- SHIFT with rd_en=0: all state holds.
- Latency: serial_out updates one cycle after the rd_en edge. The CPU samples serial_out before asserting rd_en, so read k returns buttons[k].
- Fill value: OVERREAD_VAL shifts in at the MSB.
- bit_count saturates at WIDTH. Entering WIDTH sets done=1 and serial_out=OVERREAD_VAL.
- EXHAUSTED: rd_en has no effect; serial_out stays OVERREAD_VAL indefinitely.
- rd_en held high for N cycles: N shifts, saturating at WIDTH.
- Reset mid-shift: immediately enters EXHAUSTED state values. A new strobe is required before valid data appears.
- Changes to `buttons` while strobe=0 have no effect.

Optional Feature:
- Macro: CTRL_OPEN_BUS_EN.
- When defined:
  - Adds input `open_bus_in` (1 bit).
  - In EXHAUSTED state, serial_out follows a register of open_bus_in (one-cycle latency) instead of OVERREAD_VAL.
  - This models floating bus bits.
- When undefined: the port is absent and the behaviour is exactly as specified above.

Decomposition:
- Shared package holds:
  - localparam CTRL_WIDTH_DEFAULT = 8
  - button bit index constants BTN_A=0, BTN_B=1, BTN_SELECT=2, BTN_START=3, BTN_UP=4, BTN_DOWN=5, BTN_LEFT=6, BTN_RIGHT=7
  - state encoding typedef ctrl_state_t {LOAD, SHIFT, EXHAUSTED}
- Natural sub-module: shift_cell_1b, one loadable shift stage with inputs load, load_d, shift_en, shift_d, output q. It is instantiated WIDTH times via generate.

Test Plan:
- Reset then idle: rst=1 for 1 cycle, strobe=0 -> serial_out=1, done=1, bit_count=8. Ten rd_en pulses leave all outputs unchanged.
- Basic load/read: strobe=1 with buttons=8'b1010_0101, then strobe=0; read 8 times -> serial_out sequence 1,0,1,0,0,1,0,1. The 9th and 10th reads give 1, and done=1 after the 8th.
- Strobe wins: strobe=1 and rd_en=1 together for 3 cycles with buttons=8'h01 -> bit_count stays 0 and serial_out stays 1. Change buttons to 8'h02 while strobe=0 -> first read still returns 1.
- Mid-stream reload: load 8'hFF, read 3 bits, then strobe 8'h00 -> bit_count=0, serial_out=0, and the next 8 reads return 0.
- Reset mid-shift: load 8'h00, read 2 bits, assert rst together with rd_en -> serial_out=1, done=1, bit_count=8.
- CTRL_OPEN_BUS_EN build: load 8'h00, read 8 bits, then drive open_bus_in=0 -> serial_out=0 one cycle later. Drive open_bus_in=1 -> serial_out=1.
